// File: rtl/vmac_seq_pkg.sv
// Shared sizing constants for the vector MAC sequencer.
//   VECTOR  : lanes per packed word
//   I_WIDTH : bits per lane
//   VLEN    : packed word width
//   AW      : memory address width
//   LW      : job length width (0..2^AW inclusive)
package vmac_seq_pkg;

  localparam int unsigned VECTOR  = 3;
  localparam int unsigned I_WIDTH = 16;
  localparam int unsigned VLEN    = VECTOR * I_WIDTH;
  localparam int unsigned AW      = 10;
  localparam int unsigned LW      = AW + 1;

endpackage

// File: rtl/vmac_seq_pipe.sv
// Two-stage valid / destination-address shift register tracking elements in flight
// between the operand read and the result write.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : drop every element in flight
//   in_v_i        : a read is being issued this cycle
//   in_addr_i     : result address for that element
//   s1_v_o/addr_o : element whose operands sit in the mac_* registers
//   s2_v_o/addr_o : element being written this cycle (drives o_we / o_addr)
module vmac_seq_pipe
  import vmac_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_v_i,
  input  logic [AW-1:0] in_addr_i,
  output logic          s1_v_o,
  output logic [AW-1:0] s1_addr_o,
  output logic          s2_v_o,
  output logic [AW-1:0] s2_addr_o
);

  logic          s1_v_q, s2_v_q;
  logic [AW-1:0] s1_addr_q, s2_addr_q;

  // Addresses always shift; only the valids are cleared by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s2_addr_q <= '0;
    end else begin
      s1_addr_q <= in_addr_i;
      s2_addr_q <= s1_addr_q;
      if (flush_i) begin
        s1_v_q <= 1'b0;
        s2_v_q <= 1'b0;
      end else begin
        s1_v_q <= in_v_i;
        s2_v_q <= s1_v_q;
      end
    end
  end

  assign s1_v_o    = s1_v_q;
  assign s1_addr_o = s1_addr_q;
  assign s2_v_o    = s2_v_q;
  assign s2_addr_o = s2_addr_q;

endmodule

// File: rtl/vmac_seq.sv
// Sequencer for the vector_mac datapath: streams len packed operand words from the
// A/B/C memories, feeds vector_mac and writes each result to the output memory.
//   clk, rst                  : clock, asynchronous active-high reset
//   start, abort              : command (start sampled in IDLE; abort cancels a job)
//   len, src_base, dst_base   : job description, latched at start
//   mem_en, mem_addr          : shared operand read port; rdata sampled at the edge
//                               that ends the read cycle
//   a_rdata, b_rdata, c_rdata : operand read data
//   mac_a, mac_b, mac_c       : registered operands to vector_mac
//   mac_out                   : combinational vector_mac result
//   o_we, o_addr, o_wdata     : result memory write port
//   busy, done                : job status
module vmac_seq
  import vmac_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [AW:0]     len,
  input  logic [AW-1:0]   src_base,
  input  logic [AW-1:0]   dst_base,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [VLEN-1:0] a_rdata,
  input  logic [VLEN-1:0] b_rdata,
  input  logic [VLEN-1:0] c_rdata,
  output logic [VLEN-1:0] mac_a,
  output logic [VLEN-1:0] mac_b,
  output logic [VLEN-1:0] mac_c,
  input  logic [VLEN-1:0] mac_out,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [VLEN-1:0] o_wdata,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [LW-1:0]   rem_q;
  logic            mem_en_q;
  logic [AW-1:0]   mem_addr_q;
  logic [AW-1:0]   dst_nxt_q;
  logic            busy_q;
  logic            done_q;
  logic [VLEN-1:0] mac_a_q, mac_b_q, mac_c_q;
  logic [VLEN-1:0] o_wdata_q;

  logic            issue_v_d;
  logic            flush_d;
  logic            s1_v, s2_v;
  logic [AW-1:0]   s1_addr, s2_addr;

  // An issued read enters the pipe unless the job is cancelled in the same cycle.
  always_comb begin
    issue_v_d = mem_en_q & ~abort;
    flush_d   = abort & ((state_q == ISSUE) | (state_q == DRAIN));
  end

  vmac_seq_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_d),
    .in_v_i    (issue_v_d),
    .in_addr_i (dst_nxt_q),
    .s1_v_o    (s1_v),
    .s1_addr_o (s1_addr),
    .s2_v_o    (s2_v),
    .s2_addr_o (s2_addr)
  );

  // Control FSM; rem_q counts reads still to issue including the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      dst_nxt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            if (len == LW'(0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              busy_q     <= 1'b1;
              mem_en_q   <= 1'b1;
              mem_addr_q <= src_base;
              dst_nxt_q  <= dst_base;
              rem_q      <= len;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            dst_nxt_q <= dst_nxt_q + AW'(1);
            if (rem_q == LW'(1)) begin
              state_q  <= DRAIN;
              mem_en_q <= 1'b0;
            end else begin
              rem_q      <= rem_q - LW'(1);
              mem_addr_q <= mem_addr_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!s1_v) begin
            // Last element is being written now; nothing left behind it.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand and result registers hold their value when nothing is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_c_q   <= '0;
      o_wdata_q <= '0;
    end else begin
      if (issue_v_d) begin
        mac_a_q <= a_rdata;
        mac_b_q <= b_rdata;
        mac_c_q <= c_rdata;
      end
      if (s1_v) o_wdata_q <= mac_out;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_c    = mac_c_q;
  assign o_we     = s2_v;
  assign o_addr   = s2_addr;
  assign o_wdata  = o_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_vmac_seq.sv
// Directed bench for vmac_seq with operand memories and a vector_mac model.
module tb_vmac_seq;
  import vmac_seq_pkg::*;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [AW:0]     len;
  logic [AW-1:0]   src_base, dst_base;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [VLEN-1:0] a_rdata, b_rdata, c_rdata;
  logic [VLEN-1:0] mac_a, mac_b, mac_c, mac_out;
  logic            o_we;
  logic [AW-1:0]   o_addr;
  logic [VLEN-1:0] o_wdata;
  logic            busy, done;

  logic [VLEN-1:0] mem_a [0:(1<<AW)-1];
  logic [VLEN-1:0] mem_b [0:(1<<AW)-1];
  logic [VLEN-1:0] mem_c [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int              wr_addr_q[$];
  int              wr_cyc_q[$];
  logic [VLEN-1:0] wr_data_q[$];
  int              rd_addr_q[$];
  int              rd_cyc_q[$];
  int              done_cnt = 0;
  int              done_cyc = 0;
  int              busy_cnt = 0;

  int s_cyc, w0, r0, d0, b0;

  always #5 clk = ~clk;

  vmac_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .src_base(src_base), .dst_base(dst_base), .mem_en(mem_en), .mem_addr(mem_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .c_rdata(c_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_out(mac_out),
    .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata), .busy(busy), .done(done)
  );

  assign a_rdata = mem_a[mem_addr];
  assign b_rdata = mem_b[mem_addr];
  assign c_rdata = mem_c[mem_addr];

  // vector_mac model: per lane a*b+c, truncated to the lane width
  always_comb begin
    mac_out = '0;
    for (int l = 0; l < int'(VECTOR); l++)
      mac_out[l*I_WIDTH +: I_WIDTH] = I_WIDTH'(mac_a[l*I_WIDTH +: I_WIDTH] *
                                                mac_b[l*I_WIDTH +: I_WIDTH] +
                                                mac_c[l*I_WIDTH +: I_WIDTH]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_we) begin
      wr_addr_q.push_back(int'(o_addr));
      wr_data_q.push_back(o_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (mem_en) begin
      rd_addr_q.push_back(int'(mem_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  function automatic logic [VLEN-1:0] rep(input int v);
    logic [VLEN-1:0] r;
    r = '0;
    for (int l = 0; l < int'(VECTOR); l++) r[l*I_WIDTH +: I_WIDTH] = I_WIDTH'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Element k of a job at src: A=k+1, B=2, C=1 per lane, so result lane = 2k+3.
  task automatic fill(input int src, input int n);
    for (int k = 0; k < n; k++) begin
      mem_a[AW'(src + k)] = rep(k + 1);
      mem_b[AW'(src + k)] = rep(2);
      mem_c[AW'(src + k)] = rep(1);
    end
  endtask

  task automatic snap();
    w0 = wr_addr_q.size();
    r0 = rd_addr_q.size();
    d0 = done_cnt;
    b0 = busy_cnt;
  endtask

  task automatic launch(input int l, input int src, input int dst);
    @(negedge clk);
    snap();
    len = (AW+1)'(l); src_base = AW'(src); dst_base = AW'(dst);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'(|{mem_en, mem_addr, mac_a, mac_b, mac_c, o_we, o_addr, o_wdata, busy, done}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    len = '0; src_base = '0; dst_base = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // len=4 basic job
    fill(12'h010, 4);
    launch(4, 12'h010, 12'h200);
    repeat (8) @(negedge clk);
    chk("t1_nwr", 64'(wr_addr_q.size() - w0), 64'd4);
    chk("t1_nrd", 64'(rd_addr_q.size() - r0), 64'd4);
    chk("t1_first_rd_cyc", 64'(rd_cyc_q[r0] - s_cyc), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_rd_addr%0d", k), 64'(rd_addr_q[r0+k]), 64'(12'h010 + k));
      chk($sformatf("t1_wr_addr%0d", k), 64'(wr_addr_q[w0+k]), 64'(12'h200 + k));
      chk($sformatf("t1_wr_data%0d", k), 64'(wr_data_q[w0+k]), 64'(rep(2*k + 3)));
      chk($sformatf("t1_wr_cyc%0d", k), 64'(wr_cyc_q[w0+k] - s_cyc), 64'(3 + k));
    end
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_done_after_last_en", 64'(done_cyc - rd_cyc_q[rd_cyc_q.size()-1]), 64'd3);
    chk("t1_done_cyc", 64'(done_cyc - s_cyc), 64'd7);
    chk("t1_busy_cycles", 64'(busy_cnt - b0), 64'd6);

    // len=0 job
    launch(0, 12'h000, 12'h000);
    repeat (4) @(negedge clk);
    chk("t2_done_cyc", 64'(done_cyc - s_cyc), 64'd1);
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t2_busy", 64'(busy_cnt - b0), 64'd0);
    chk("t2_nrd", 64'(rd_addr_q.size() - r0), 64'd0);
    chk("t2_nwr", 64'(wr_addr_q.size() - w0), 64'd0);

    // address wrap
    fill(12'h3FE, 3);
    launch(3, 12'h3FE, 12'h3FF);
    repeat (8) @(negedge clk);
    chk("t3_nwr", 64'(wr_addr_q.size() - w0), 64'd3);
    chk("t3_rd0", 64'(rd_addr_q[r0]),   64'h3FE);
    chk("t3_rd1", 64'(rd_addr_q[r0+1]), 64'h3FF);
    chk("t3_rd2", 64'(rd_addr_q[r0+2]), 64'h000);
    chk("t3_wr0", 64'(wr_addr_q[w0]),   64'h3FF);
    chk("t3_wr1", 64'(wr_addr_q[w0+1]), 64'h000);
    chk("t3_wr2", 64'(wr_addr_q[w0+2]), 64'h001);
    chk("t3_data2", 64'(wr_data_q[w0+2]), 64'(rep(7)));
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // abort two cycles into a len=8 job
    fill(12'h040, 8);
    launch(8, 12'h040, 12'h100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy_low", 64'(busy), 64'd0);
    chk("t4_mem_en_low", 64'(mem_en), 64'd0);
    chk("t4_we_low", 64'(o_we), 64'd0);
    repeat (10) @(negedge clk);
    chk("t4_at_most_one_wr", 64'((wr_addr_q.size() - w0) <= 1), 64'd1);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);

    // start pulsed again while busy
    fill(12'h080, 5);
    launch(5, 12'h080, 12'h300);
    len = (AW+1)'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_nwr", 64'(wr_addr_q.size() - w0), 64'd5);
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t5_done_cyc", 64'(done_cyc - s_cyc), 64'd8);
    chk("t5_last_addr", 64'(wr_addr_q[w0+4]), 64'h304);
    chk("t5_last_data", 64'(wr_data_q[w0+4]), 64'(rep(11)));

    // abort and start together in IDLE
    @(negedge clk);
    snap();
    len = (AW+1)'(3); start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_busy", 64'(busy_cnt - b0), 64'd0);
    chk("t6_no_rd", 64'(rd_addr_q.size() - r0), 64'd0);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);

    // async reset while draining
    fill(12'h0A0, 4);
    launch(4, 12'h0A0, 12'h050);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("t7_rst_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (3) @(negedge clk);
    chk("t7_no_wr_after_rst", 64'(wr_addr_q.size() - w0), 64'd0);
    chk("t7_no_done_after_rst", 64'(done_cnt - d0), 64'd0);

    // clean len=1 job after reset
    fill(12'h001, 1);
    launch(1, 12'h001, 12'h3FF);
    repeat (6) @(negedge clk);
    chk("t8_nwr", 64'(wr_addr_q.size() - w0), 64'd1);
    chk("t8_addr", 64'(wr_addr_q[w0]), 64'h3FF);
    chk("t8_data", 64'(wr_data_q[w0]), 64'(rep(3)));
    chk("t8_done_cyc", 64'(done_cyc - s_cyc), 64'd4);
    chk("t8_done_cnt", 64'(done_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
